signal_generate: RTL and testbench
==================================

Name: signal_generate

Overview:
Generates a burst of square-wave periods on a single-bit output. Each period is low for H clock cycles, then high for H clock cycles. The block emits registered edge-strobe pulses aligned with each output transition. It is the producing counterpart to the switch's edge/level detection logic, and it drives management-style serial clocks (e.g. MDC) and test strobes. A start/busy/done handshake controls it, and an abort input stops a burst early.

Parameters:
HALF_WIDTH, 8, width of half_period; sets the maximum half-period in clock cycles.
COUNT_WIDTH, 8, width of cycles; sets the maximum number of periods per burst.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request; sampled only in IDLE
half_period  input  HALF_WIDTH  cycles per half-period (H); latched on accepted start
cycles  input  COUNT_WIDTH  number of periods (N); latched on accepted start
abort  input  1  terminate the current burst
signal_out  output  1  generated waveform, registered
edge_positive  output  1  one-cycle pulse in the cycle signal_out first reads 1
edge_negative  output  1  one-cycle pulse in the cycle signal_out first reads 0
busy  output  1  burst in progress
done  output  1  one-cycle pulse on normal burst completion

Behaviour:
- Interface: reset is reset, asynchronous, active-high; the clock is clock.
- Reset values: signal_out=0, edge_positive=0, edge_negative=0, busy=0, done=0, state=IDLE, all counters 0.
- All outputs are registered. There is no combinational path from any input to any output.
- States:
  - IDLE: waiting for start.
  - LOW: signal_out=0, counting H cycles.
  - HIGH: signal_out=1, counting H cycles.
- IDLE, start=1, N!=0, sampled at cycle T:
  - Latch H (a value of 0 is treated as 1) and N.
  - From T+1: busy=1, state LOW.
- IDLE, start=1, N==0: no state change and no toggling; done=1 at T+1 only.
- LOW lasts exactly H cycles. Then signal_out=1 and edge_positive=1 in the same cycle, and the state goes to HIGH.
- HIGH lasts exactly H cycles. Then signal_out=0 and edge_negative=1 in the same cycle, and the remaining count is decremented.
  - If the remaining count is nonzero: state LOW.
  - If it reaches 0: state IDLE, busy=0, done=1, all in the same cycle as the final edge_negative.
- Timing: busy covers T+1 .. T+2·N·H. Rising edges occur at T+1+2kH+H and falling edges at T+1+2kH+2H, for k=0..N-1.
- start while busy is ignored; the latched H and N are unaffected. Changes to H and N inputs mid-burst are ignored.
- abort=1 while busy, at cycle A:
  - At A+1: state IDLE, busy=0, signal_out=0, done=0.
  - edge_negative=1 at A+1 only if signal_out was 1 at A.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: abort wins and start is dropped.
- Counter widths:
  - Half-period counter: HALF_WIDTH bits, counting down from H-1.
  - Remaining count: COUNT_WIDTH bits.
  - Neither counter wraps: each counter is reloaded before it underflows.
  - Maximum H (2^HALF_WIDTH-1) and maximum N are supported exactly.
- Invariants:
  - edge_positive and edge_negative are never high simultaneously.
  - Each edge pulse lasts exactly one cycle.
  - done and busy are never high simultaneously.
- Asynchronous reset mid-burst returns immediately to the reset values, with no edge or done pulse.

Decomposition:
- Shared package signal_pkg:
  - Enum signal_gen_state_t {IDLE, LOW, HIGH}.
  - Default width constants SIGNAL_HALF_WIDTH=8 and SIGNAL_COUNT_WIDTH=8.
- Sub-module period_counter: loadable down-counter with load, enable and a registered terminal flag. It is instantiated once for the half-period. The period count stays inline in signal_generate.

Test Plan:
- H=2, N=3, start at T:
  - busy high T+1..T+12.
  - Rises at T+3, T+7, T+11, each with edge_positive.
  - Falls at T+5, T+9, T+13, each with edge_negative.
  - done=1 only at T+13.
- H=0, N=1: treated as H=1. Rise at T+2, fall at T+3, done at T+3.
- N=0 start: done=1 at T+1 only; signal_out, busy and both edge outputs stay 0.
- H=4, N=5, abort asserted while signal_out=1:
  - Next cycle: signal_out=0, edge_negative=1, busy=0, done=0.
  - Repeat with abort while signal_out=0: no edge pulse.
- start pulsed repeatedly while busy (H=3, N=2), with half_period/cycles changed mid-burst: waveform identical to an undisturbed H=3, N=2 burst, with exactly one done pulse.
- Reset asserted asynchronously mid-HIGH phase: all outputs 0 immediately. After release, a new start with H=1, N=1 gives rise at T+2 and fall/done at T+3.

Source files
------------

// File: rtl/signal_pkg.sv
// signal_pkg: shared state type and default widths for the signal generator
//    signal_gen_state_t : IDLE / LOW / HIGH phase of a burst
//    SIGNAL_HALF_WIDTH  : default width of the half-period value
//    SIGNAL_COUNT_WIDTH : default width of the period count
package signal_pkg;
   typedef enum logic [1:0] {IDLE, LOW, HIGH} signal_gen_state_t;
   localparam int SIGNAL_HALF_WIDTH  = 8;
   localparam int SIGNAL_COUNT_WIDTH = 8;
endpackage

// File: rtl/signal_generate_period_counter.sv
// period_counter: loadable down-counter with a registered terminal flag
//    clock, reset : clock and asynchronous active-high reset
//    load         : load load_value (has priority over enable)
//    enable       : count down by one, holding at zero
//    load_value   : value to load
//    terminal     : registered flag, high while the count is zero
module period_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic             enable,
   input  logic [WIDTH-1:0] load_value,
   output logic             terminal
);
   logic [WIDTH-1:0] count_q, count_d;
   logic             terminal_q, terminal_d;
   always_comb begin
      count_d    = load ? load_value : (enable && count_q != '0) ? count_q - WIDTH'(1) : count_q;
      terminal_d = (count_d == '0);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q    <= '0;
         terminal_q <= 1'b1;
      end else begin
         count_q    <= count_d;
         terminal_q <= terminal_d;
      end
   end
   assign terminal = terminal_q;
endmodule

// File: rtl/signal_generate.sv
// signal_generate: bursts of N square-wave periods, each H cycles low then H cycles high
//    clock, reset        : clock and asynchronous active-high reset
//    start               : burst request, honoured only while idle
//    half_period, cycles : H and N, latched when a burst starts (H of 0 behaves as 1)
//    abort               : end the current burst at once
//    signal_out          : registered waveform
//    edge_positive/negative : one-cycle strobes in the first cycle of each new level
//    busy, done          : burst in progress / one-cycle normal completion pulse
module signal_generate
   import signal_pkg::*;
#(
   parameter int HALF_WIDTH  = SIGNAL_HALF_WIDTH,
   parameter int COUNT_WIDTH = SIGNAL_COUNT_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [HALF_WIDTH-1:0]  half_period,
   input  logic [COUNT_WIDTH-1:0] cycles,
   input  logic                   abort,
   output logic                   signal_out,
   output logic                   edge_positive,
   output logic                   edge_negative,
   output logic                   busy,
   output logic                   done
);
   signal_gen_state_t      state_q, state_d;
   logic [HALF_WIDTH-1:0]  reload_q, reload_d;
   logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
   logic                   signal_q, signal_d;
   logic                   edge_pos_q, edge_pos_d;
   logic                   edge_neg_q, edge_neg_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   load, enable, terminal;
   logic [HALF_WIDTH-1:0]  load_value, start_reload;
   // The half-period counter runs from H-1 down to 0, so H=0 and H=1 share reload 0
   assign start_reload = (half_period == '0) ? '0 : half_period - HALF_WIDTH'(1);
   period_counter #(.WIDTH(HALF_WIDTH)) u_half (
      .clock      (clock),
      .reset      (reset),
      .load       (load),
      .enable     (enable),
      .load_value (load_value),
      .terminal   (terminal)
   );
   always_comb begin
      state_d     = state_q;
      reload_d    = reload_q;
      remaining_d = remaining_q;
      signal_d    = signal_q;
      busy_d      = busy_q;
      edge_pos_d  = 1'b0;
      edge_neg_d  = 1'b0;
      done_d      = 1'b0;
      load        = 1'b0;
      load_value  = reload_q;
      enable      = (state_q != IDLE);
      if (state_q == IDLE) begin
         if (start && !abort) begin
            if (cycles == '0) begin
               done_d = 1'b1;
            end else begin
               reload_d    = start_reload;
               remaining_d = cycles;
               load        = 1'b1;
               load_value  = start_reload;
               busy_d      = 1'b1;
               state_d     = LOW;
            end
         end
      end else if (abort) begin
         state_d    = IDLE;
         busy_d     = 1'b0;
         signal_d   = 1'b0;
         edge_neg_d = signal_q;
      end else if (terminal) begin
         load = 1'b1;
         if (state_q == LOW) begin
            signal_d   = 1'b1;
            edge_pos_d = 1'b1;
            state_d    = HIGH;
         end else begin
            // remaining reaches zero together with the return to IDLE, so it never wraps
            signal_d    = 1'b0;
            edge_neg_d  = 1'b1;
            remaining_d = remaining_q - COUNT_WIDTH'(1);
            state_d     = (remaining_q == COUNT_WIDTH'(1)) ? IDLE : LOW;
            busy_d      = (remaining_q != COUNT_WIDTH'(1));
            done_d      = (remaining_q == COUNT_WIDTH'(1));
         end
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         reload_q    <= '0;
         remaining_q <= '0;
         signal_q    <= 1'b0;
         edge_pos_q  <= 1'b0;
         edge_neg_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         reload_q    <= reload_d;
         remaining_q <= remaining_d;
         signal_q    <= signal_d;
         edge_pos_q  <= edge_pos_d;
         edge_neg_q  <= edge_neg_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end
   assign signal_out    = signal_q;
   assign edge_positive = edge_pos_q;
   assign edge_negative = edge_neg_q;
   assign busy          = busy_q;
   assign done          = done_q;
endmodule

// File: tb/tb_signal_generate.sv
// tb_signal_generate: directed checks of burst timing, abort, N=0, H=0 and async reset
module tb_signal_generate;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] half_period = '0;
   logic [7:0] cycles = '0;
   logic       signal_out, edge_positive, edge_negative, busy, done;
   int         errors = 0;
   int         checks = 0;
   signal_generate dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .half_period   (half_period),
      .cycles        (cycles),
      .abort         (abort),
      .signal_out    (signal_out),
      .edge_positive (edge_positive),
      .edge_negative (edge_negative),
      .busy          (busy),
      .done          (done)
   );
   always #5 clock = ~clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic chk_all(input string tag, input bit s, input bit ep, input bit en, input bit b, input bit d);
      chk({tag, " signal_out"}, signal_out, s);
      chk({tag, " edge_positive"}, edge_positive, ep);
      chk({tag, " edge_negative"}, edge_negative, en);
      chk({tag, " busy"}, busy, b);
      chk({tag, " done"}, done, d);
   endtask
   // Called at a falling edge; cycle T is the one in which start is presented.
   // k counts cycles after T: rises at k=1+2jH+H, falls at k=1+2jH+2H, done at k=2NH+1.
   task automatic run_burst(input string name, input int h_in, input int n_in, input int h_eff, input bit disturb);
      int last, p;
      last = 2 * n_in * h_eff;
      half_period = 8'(h_in);
      cycles = 8'(n_in);
      start = 1'b1;
      for (int k = 1; k <= last + 2; k++) begin
         @(negedge clock);
         p = (k - 1) % (2 * h_eff);
         chk_all($sformatf("%s k=%0d", name, k), k <= last && p >= h_eff, k <= last && p == h_eff,
                 k > 1 && k <= last + 1 && p == 0, k <= last, k == last + 1);
         start = disturb && k < last && (k % 3 == 0);
         if (disturb) begin
            half_period = 8'($urandom_range(1, 9));
            cycles = 8'($urandom_range(0, 9));
         end
      end
      start = 1'b0;
   endtask
   // H=4, N=5 burst aborted during cycle at_k
   task automatic abort_at(input string name, input int at_k, input bit exp_edge);
      half_period = 8'd4;
      cycles = 8'd5;
      start = 1'b1;
      for (int k = 1; k <= at_k; k++) begin
         @(negedge clock);
         start = 1'b0;
         chk($sformatf("%s k=%0d signal_out", name, k), signal_out, ((k - 1) % 8) >= 4);
      end
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      chk_all({name, " next"}, 1'b0, 1'b0, exp_edge, 1'b0, 1'b0);
      @(negedge clock);
      chk_all({name, " after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask
   initial begin
      repeat (2) @(negedge clock);
      chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      run_burst("h2n3", 2, 3, 2, 1'b0);
      run_burst("h0n1", 0, 1, 1, 1'b0);
      run_burst("n0", 5, 0, 5, 1'b0);
      abort_at("abort_hi", 6, 1'b1);
      abort_at("abort_lo", 2, 1'b0);
      half_period = 8'd2;
      cycles = 8'd2;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      chk_all("abort_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      chk_all("abort_start2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_burst("disturb", 3, 2, 3, 1'b1);
      half_period = 8'd2;
      cycles = 8'd3;
      start = 1'b1;
      repeat (3) begin
         @(negedge clock);
         start = 1'b0;
      end
      chk("pre_reset signal_out", signal_out, 1'b1);
      #2 reset = 1'b1;
      #1 chk_all("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      reset = 1'b0;
      chk_all("reset_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_burst("post_rst", 1, 1, 1, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
